alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits, any even value >= 8.
REQ-002 Parameter FAST_SPECIAL, default 1: when 1, divide-by-zero and signed-overflow divides complete without iterating.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 a, b  input  XLEN each  a = multiplicand/dividend, b = multiplier/divisor.
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  operation result.
REQ-013 N, Z  output  1 each  result[XLEN-1]; result == 0.
REQ-014 busy  output  1  high in BUSY or DONE.

Function
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->BUSY on in_valid & in_ready; BUSY->DONE after XLEN iteration cycles; DONE->IDLE on out_valid & out_ready.
REQ-016 Operands and op are captured at acceptance; later input changes have no effect.
REQ-017 Iterative path: result out_valid exactly XLEN+1 cycles after the acceptance edge (XLEN BUSY cycles, then DONE).
REQ-018 Multiply: radix-2 shift-add on operand magnitudes, 2*XLEN-bit product, sign corrected at completion; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed×signed, signed×unsigned, unsigned×unsigned interpretation.
REQ-019 Divide: radix-2 restoring division on magnitudes; quotient negated when signs differ (signed ops), remainder takes dividend sign; truncation toward zero.
REQ-020 Divide by zero: DIV/DIVU return all ones, REM/REMU return a.
REQ-021 Signed overflow (a = most negative value, b = all ones) for DIV returns a, for REM returns 0.
REQ-022 With FAST_SPECIAL=1, REQ-020/021 cases go IDLE->DONE with out_valid one cycle after acceptance; with 0 they take the full XLEN+1 latency with identical results.
REQ-023 result, N, Z held stable while out_valid high and out_ready low.
REQ-024 flush in any state forces IDLE next cycle, drops out_valid, discards partial state; flush has priority over acceptance and completion in the same cycle.
REQ-025 in_ready is low in DONE even if out_ready is high; back-to-back operations incur one IDLE cycle.
REQ-026 Outputs are registered; no combinational path from in_valid/a/b/op to result or out_valid.

Reset
REQ-027 reset forces IDLE; in_ready=1 after reset deasserts, out_valid=0, busy=0, result=0, N=0, Z=1.
REQ-028 reset mid-operation discards the operation with no out_valid pulse; reset has priority over flush and all handshakes.

Structure
REQ-029 Shared package alu_muldiv_pkg holds the op encoding enum, FSM state enum, and the op-class helper constants (is_div, is_signed_a, is_signed_b, want_high).
REQ-030 One sub-module, muldiv_step: combinational single-iteration datapath (add-shift or subtract-restore) parametrised on XLEN, instanced once.
REQ-031 Iteration counter width is $clog2(XLEN)+1 bits; no other counters.

Verification
REQ-032 XLEN=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, N=1, out_valid at acceptance+33.
REQ-033 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000, Z=1.
REQ-034 DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 -> 0xFFFFFFFF and REMU -> 100; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 one cycle after acceptance (FAST_SPECIAL=1).
REQ-036 out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready low; then accepted, IDLE next cycle.
REQ-037 flush at BUSY cycle 10, and separately reset at BUSY cycle 10 -> no out_valid, in_ready high next cycle, following DIVU 9/2 returns 4.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Also holds the per-op helpers that decide signedness and which half of the result is returned.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic want_high(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration on the {hi, lo} pair.
// In multiply mode it does a shift-add; in divide mode it does a subtract-restore.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        diff    = shifted - {1'b0, opd_i};
        if (div_i) begin
            // Partial remainder stays below the divisor, so diff's top bit is a clean borrow flag.
            if (!diff[XLEN]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with a valid/ready handshake on both sides.
// Multiply and divide work on operand magnitudes; the sign is fixed up on the way into the result register.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            N,
    output logic            Z,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(XLEN) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, res_q, res_d;
    op_e             op_q, op_d;
    logic            neg_q, neg_d, aneg_q, aneg_d;

    op_e             op_in;
    logic            a_neg, b_neg, b_zero, ovf, special, last_step;
    logic [XLEN-1:0] a_mag, b_mag, step_hi, step_lo;

    function automatic logic [XLEN-1:0] finalize(input op_e o, input logic neg, input logic aneg,
                                                  input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        p = {hi, lo};
        if (neg) p = -p;
        if (o == OP_REM || o == OP_REMU) return aneg ? -hi : hi;
        if (is_div(o))                   return neg ? -lo : lo;
        return want_high(o) ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i (is_div(op_q)),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .opd_i (opd_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    always_comb begin
        op_in     = op_e'(op);
        a_neg     = is_signed_a(op_in) & a[XLEN-1];
        b_neg     = is_signed_b(op_in) & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        b_zero    = (b == '0);
        ovf       = is_signed_b(op_in) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special   = FAST_SPECIAL && is_div(op_in) && (b_zero || ovf);
        last_step = (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid)  state_d = special ? ST_DONE : ST_BUSY;
                ST_BUSY: if (last_step) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default:                state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
        state_dbg = state_q;
        result    = res_q;
        N         = res_q[XLEN-1];
        Z         = (res_q == '0);
    end

    // A divide by zero keeps the all-ones quotient unsigned, so it never takes the sign fix.
    always_comb begin
        hi_d = hi_q; lo_d = lo_q; opd_d = opd_q; res_d = res_q;
        op_d = op_q; neg_d = neg_q; aneg_d = aneg_q; cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (state_q == ST_IDLE && in_valid) begin
            op_d   = op_in;
            neg_d  = (a_neg ^ b_neg) & ~(is_div(op_in) & b_zero);
            aneg_d = a_neg;
            cnt_d  = '0;
            if (special) begin
                hi_d  = b_zero ? a_mag : '0;
                lo_d  = b_zero ? '1 : a_mag;
                res_d = finalize(op_in, neg_d, a_neg, hi_d, lo_d);
            end else begin
                hi_d  = '0;
                lo_d  = is_div(op_in) ? a_mag : b_mag;
                opd_d = is_div(op_in) ? b_mag : a_mag;
            end
        end else if (state_q == ST_BUSY) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last_step) res_d = finalize(op_q, neg_q, aneg_q, step_hi, step_lo);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0; lo_q <= '0; opd_q <= '0; res_q <= '0;
            op_q <= OP_MUL; neg_q <= 1'b0; aneg_q <= 1'b0; cnt_q <= '0;
        end else begin
            hi_q <= hi_d; lo_q <= lo_d; opd_q <= opd_d; res_q <= res_d;
            op_q <= op_d; neg_q <= neg_d; aneg_q <= aneg_d; cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and random checks of alu_muldiv against a 64-bit arithmetic reference.
// Expected results and latencies are queued when an op is sent and compared when out_valid rises.
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset, in_valid, flush, out_ready;
    logic in_ready, out_valid, N, Z, busy;
    logic [2:0] op;
    logic [XLEN-1:0] a, b, result;
    logic [1:0] state_dbg;

    logic [XLEN-1:0] exp_q[$];
    int exp_lat_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .N(N), .Z(Z), .busy(busy), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, uy_s;
        logic [63:0] ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        uy_s = uy;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy_s; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN_NEG && y == 32'hFFFF_FFFF) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 3'd4 && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == MIN_NEG && y == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    // Presents one op, returns 1 time unit after the accepting edge with scrambled inputs.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("send_in_ready", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        if (track) begin
            exp_q.push_back(model(o, x, y));
            exp_lat_q.push_back(model_lat(o, x, y));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic collect(input int hold);
        int n = 1;
        int el;
        logic [31:0] e, r0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        check("latency", n, el);
        check("result", result, e);
        check("N", N, e[31]);
        check("Z", Z, e == 0);
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, r0);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_accept_in_ready", in_ready, 1);
        check("post_accept_valid", out_valid, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_N", N, 0);
        check("rst_Z", Z, 1);
        check("rst_state", state_dbg, 0);

        send(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("busy_in_busy", busy, 1);
        check("busy_in_ready", in_ready, 0);
        collect(0);

        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); collect(0);
        send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); collect(0);
        send(3'd2, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1); collect(0);
        send(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1); collect(0);
        send(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1); collect(0);
        send(3'd5, 32'd100, 32'd0, 1'b1); collect(0);
        send(3'd7, 32'd100, 32'd0, 1'b1); collect(0);
        send(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1); collect(0);
        send(3'd4, MIN_NEG, 32'hFFFF_FFFF, 1'b1); collect(0);
        send(3'd6, MIN_NEG, 32'hFFFF_FFFF, 1'b1); collect(0);

        // Consumer stalls for five cycles in DONE.
        send(3'd5, 32'd1000, 32'd7, 1'b1); collect(5);

        // Flush at BUSY cycle 10.
        send(3'd5, 32'd5000, 32'd3, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        check("flush_pre_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        expect_quiet("flush_no_valid", 40);
        send(3'd5, 32'd9, 32'd2, 1'b1); collect(0);

        // Reset at BUSY cycle 10.
        send(3'd4, 32'hFFFF_0000, 32'd5, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid_in_ready", in_ready, 1);
        check("reset_mid_out_valid", out_valid, 0);
        check("reset_mid_result", result, 0);
        check("reset_mid_Z", Z, 1);
        expect_quiet("reset_no_valid", 40);
        send(3'd5, 32'd9, 32'd2, 1'b1); collect(0);

        // Flush wins over an acceptance in IDLE.
        op = 3'd0; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept_ready", in_ready, 1);
        check("flush_vs_accept_busy", busy, 0);

        // Flush in DONE drops out_valid.
        send(3'd0, 32'd6, 32'd7, 1'b0);
        repeat (40) begin
            if (!out_valid) begin @(posedge clk); #1; end
        end
        check("done_reached", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_valid", out_valid, 0);
        check("flush_done_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            logic [2:0] ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 6) rb = 32'($urandom_range(1, 15));
            send(ro, ra, rb, 1'b1);
            collect(i % 3);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
